mbus_mem_ctl: RTL
=================

MBUS_MEM_CTL -- requirements
Module: mbus_mem_ctl

Interface
REQ-001 Param DEPTH_LOG2, default 14, memory depth in 36-bit words (2**DEPTH_LOG2).
REQ-002 Param N_PORTS, default 2, number of start/ack/valid port channels (generalises A/B).
REQ-003 Param READ_LAT, default 2, idle cycles from ack to first read-data beat (>=1).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  N_PORTS  per-port request strobe.
REQ-007 rdRq, wrRq  in  1 each  read/write type, sampled with start.
REQ-008 rq  in  4  word-enable mask, bit i selects quad word i.
REQ-009 adr  in  22  word address [14:35]; adr[34:35] is the starting word in the quad.
REQ-010 adrPar  in  1  odd parity over adr.
REQ-011 dOut, parOut  in  36, 1  write data from MBOX, odd parity.
REQ-012 outValid  in  N_PORTS  write data beat valid, per port.
REQ-013 ackn  out  N_PORTS  one-cycle request acknowledge.
REQ-014 inValid  out  N_PORTS  read data beat valid.
REQ-015 dIn, parIn  out  36, 1  read data, odd parity.
REQ-016 error  out  1  sticky error flag.
REQ-017 adrParErr  out  1  one-cycle pulse on a rejected address-parity request.

Function
REQ-018 States: IDLE, ACK, RWAIT, RDATA, WDATA; exactly one active.
REQ-019 In IDLE, the block SHALL pick one asserted start[i] per cycle by round-robin, beginning after the last granted port; after reset, port 0 has highest priority.
REQ-020 If the request has bad adrPar: no ack, adrParErr pulses 1 cycle, error sets, and the state stays IDLE.
REQ-021 If the quad address is >= 2**DEPTH_LOG2 (nonexistent memory): no ack, no error, and the state stays IDLE.
REQ-022 If rq==0 or rdRq==wrRq: no ack, and the state stays IDLE.
REQ-023 A valid request SHALL be latched and move the state to ACK; ackn[port] asserts on the next cycle for exactly 1 cycle.
REQ-024 Read: ACK -> RWAIT for READ_LAT cycles -> RDATA.
REQ-025 Write: ACK -> WDATA.
REQ-026 Beat order SHALL start at adr[34:35] and increment mod 4, skipping words with a clear rq bit; each enabled word gets exactly one beat.
REQ-027 RDATA SHALL emit one beat per cycle: inValid[port]=1, dIn=mem[quad,word], parIn=~^dIn; words never written read as 0.
REQ-028 WDATA SHALL write the current word on each cycle with outValid[port]=1; outValid on other ports is ignored.
REQ-029 A write beat with a parOut mismatch SHALL still write the data and SHALL set error.
REQ-030 After the last enabled beat, the state SHALL return to IDLE; a new grant is possible in the following cycle.
REQ-031 Starts arriving while not IDLE SHALL NOT be latched; the requester holds start until ackn.
REQ-032 All unconnected outputs are 0 when not driving.

Reset
REQ-033 On reset assertion (async): state=IDLE, ackn=0, inValid=0, dIn=0, parIn=0, error=0, adrParErr=0, round-robin pointer=port 0; an in-flight transfer is abandoned; memory contents are unspecified.

Verification
REQ-034 Port 0 write: adr=0x000104, rq=1111, words W0..W3 -> ackn[0] 1 cycle; mem[0x104..0x107] are written in order 0x104,0x105,0x106,0x107.
REQ-035 Port 1 read: adr=0x000106, rq=1111, READ_LAT=2 -> ackn[1]; 2 idle cycles; then 4 consecutive inValid[1] beats with words 2,3,0,1; parIn odd on each.
REQ-036 Ports 0 and 1 start in the same cycle, twice in a row -> port 0 is granted first, then port 1; on the next simultaneous pair, port 0 is granted after port 1.
REQ-037 Bad adrPar -> adrParErr pulses, error=1, no ackn; adr=0x3FFFFC with DEPTH_LOG2=14 -> no ackn, error unchanged.
REQ-038 Read rq=0101 at adr word 3 -> beats for words 0 then 2 only; reset asserted mid-RDATA -> inValid drops immediately and the state is IDLE.

Source files
------------

// File: rtl/mbus_mem_ctl.sv
// rtl/mbus_mem_ctl.sv - multi-port quad-word memory controller for the MBOX bus.
// Round-robin request arbitration, parity checking and wrapped quad-word burst transfers.
module mbus_mem_ctl #(
  parameter int DEPTH_LOG2 = 14,
  parameter int N_PORTS    = 2,
  parameter int READ_LAT   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] start,
  input  logic               rdRq,
  input  logic               wrRq,
  input  logic [3:0]         rq,
  input  logic [21:0]        adr,
  input  logic               adrPar,
  input  logic [35:0]        dOut,
  input  logic               parOut,
  input  logic [N_PORTS-1:0] outValid,
  output logic [N_PORTS-1:0] ackn,
  output logic [N_PORTS-1:0] inValid,
  output logic [35:0]        dIn,
  output logic               parIn,
  output logic               error,
  output logic               adrParErr
);

  localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ACK   = 3'd1;
  localparam logic [2:0] RWAIT = 3'd2;
  localparam logic [2:0] RDATA = 3'd3;
  localparam logic [2:0] WDATA = 3'd4;

  logic [2:0]            state;
  logic [PW-1:0]         rrPtr;
  logic [PW-1:0]         port;
  logic [PW-1:0]         pick;
  logic                  pickValid;
  logic                  isRead;
  logic [DEPTH_LOG2-3:0] quad;
  logic [1:0]            cur;
  logic [3:0]            remain;
  logic [3:0]            restMask;
  logic [CW-1:0]         cnt;
  logic [DEPTH_LOG2-1:0] wAddr;
  logic                  wrEn;
  logic                  parOk;
  logic                  nxm;
  logic                  typeOk;
  logic [DEPTH-1:0]      written;
  logic [35:0]           mem [DEPTH];
  int                    idx;

  // First enabled word at or after 'from', wrapping within the quad.
  function automatic logic [1:0] firstFrom(input logic [3:0] mask, input logic [1:0] from);
    logic [1:0] w;
    firstFrom = from;
    for (int k = 3; k >= 0; k--) begin
      w = from + 2'(k);
      if (mask[w]) firstFrom = w;
    end
  endfunction

  always_comb begin
    pickValid = 1'b0;
    pick      = '0;
    idx       = 0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = (int'(rrPtr) + k) % N_PORTS;
      if (start[idx]) begin
        pickValid = 1'b1;
        pick      = PW'(idx);
      end
    end
  end

  assign parOk    = ^{adr, adrPar};
  assign nxm      = {1'b0, adr} >= 23'(DEPTH);
  assign typeOk   = (rq != 4'b0000) && (rdRq != wrRq);
  assign wAddr    = {quad, cur};
  assign wrEn     = (state == WDATA) && outValid[port];
  assign restMask = remain & ~(4'b0001 << cur);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rrPtr     <= '0;
      port      <= '0;
      isRead    <= 1'b0;
      quad      <= '0;
      cur       <= '0;
      remain    <= '0;
      cnt       <= '0;
      error     <= 1'b0;
      adrParErr <= 1'b0;
      written   <= '0;
    end else begin
      adrParErr <= 1'b0;
      if (wrEn) written[wAddr] <= 1'b1;
      case (state)
        IDLE: begin
          if (pickValid) begin
            if (!parOk) begin
              adrParErr <= 1'b1;
              error     <= 1'b1;
            end else if (!nxm && typeOk) begin
              state  <= ACK;
              port   <= pick;
              rrPtr  <= (int'(pick) == N_PORTS - 1) ? '0 : pick + 1'b1;
              isRead <= rdRq;
              quad   <= adr[DEPTH_LOG2-1:2];
              remain <= rq;
              cur    <= firstFrom(rq, adr[1:0]);
            end
          end
        end
        ACK: begin
          if (isRead) begin
            state <= RWAIT;
            cnt   <= CW'(READ_LAT - 1);
          end else begin
            state <= WDATA;
          end
        end
        RWAIT: begin
          if (cnt == '0) state <= RDATA;
          else cnt <= cnt - 1'b1;
        end
        RDATA: begin
          remain <= restMask;
          cur    <= firstFrom(restMask, cur + 2'd1);
          if (restMask == 4'b0000) state <= IDLE;
        end
        WDATA: begin
          if (outValid[port]) begin
            // Bad write-data parity is flagged but the word is still stored.
            if (!(^{dOut, parOut})) error <= 1'b1;
            remain <= restMask;
            cur    <= firstFrom(restMask, cur + 2'd1);
            if (restMask == 4'b0000) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wAddr] <= dOut;
  end

  always_comb begin
    ackn    = '0;
    inValid = '0;
    dIn     = '0;
    if (state == ACK) ackn[port] = 1'b1;
    if (state == RDATA) begin
      inValid[port] = 1'b1;
      dIn           = written[wAddr] ? mem[wAddr] : 36'h0;
    end
  end

  assign parIn = (state == RDATA) ? ~^dIn : 1'b0;

endmodule
